// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: shares a single-port frame memory between raster prefetch (FWFT FIFO) and host writes.
// Define FETCH_STATS_EN to build the saturating underflow event counter on underflow_cnt.
module frame_mem_arbiter #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic              clk_25,
  input  logic              n_rst,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [DATA_W-1:0] pix_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              underflow,
  output logic [15:0]       underflow_cnt
);

  localparam int unsigned H_WORDS = H_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned V_WORDS = V_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned REPS    = 1 << SCALE_SHIFT;
  localparam int unsigned COL_W   = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
  localparam int unsigned ROW_W   = (V_WORDS > 1) ? $clog2(V_WORDS) : 1;
  localparam int unsigned REP_W   = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_ACTIVE, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [REP_W-1:0]   r_rep;
  logic [ADDR_W-1:0]  r_line_base;
  logic               r_inflight;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [DATA_W-1:0]  r_fifo [FIFO_DEPTH];
  logic [REP_W-1:0]   r_subpix;
  logic               r_underflow;
  logic [DATA_W-1:0]  r_pix_hold;

  logic               w_fetching, w_rd, w_wr, w_last_col, w_last_rep, w_last_row, w_last_word;
  logic               w_empty, w_push, w_pop, w_uflow;
  logic [ADDR_W-1:0]  w_rd_addr;

  assign w_fetching  = (r_state == S_PREFILL) || (r_state == S_ACTIVE);
  // The raster owns the slot whenever FIFO plus in-flight read leaves room.
  assign w_rd        = n_rst && !frame_start && w_fetching &&
                       ((r_count + CNT_W'(r_inflight)) < CNT_W'(FIFO_DEPTH));
  assign w_wr        = n_rst && !w_rd && wr_req;
  assign w_last_col  = (r_col == COL_W'(H_WORDS - 1));
  assign w_last_rep  = (r_rep == REP_W'(REPS - 1));
  assign w_last_row  = (r_row == ROW_W'(V_WORDS - 1));
  assign w_last_word = w_last_col && w_last_rep && w_last_row;
  // row*H_WORDS is tracked incrementally in r_line_base instead of multiplied out.
  assign w_rd_addr   = r_line_base + ADDR_W'(r_col);
  assign w_empty     = (r_count == '0);
  assign w_push      = r_inflight;
  assign w_pop       = pix_req && !w_empty && (r_subpix == REP_W'(REPS - 1));
  assign w_uflow     = pix_req && w_empty;

  always_ff @(posedge clk_25) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_we      = w_wr;
    wr_ack      = w_wr;
    mem_addr    = w_wr ? wr_addr : w_rd_addr;
    mem_wdata   = w_wr ? wr_data : '0;
    pix_data    = w_empty ? (pix_req ? '0 : r_pix_hold) : r_fifo[r_rptr];
    case (r_state)
      S_PREFILL: if (r_count == CNT_W'(FIFO_DEPTH)) w_state_nxt = S_ACTIVE;
      default:   w_state_nxt = r_state;
    endcase
    if (w_rd && w_last_word) w_state_nxt = S_DONE;
    if (frame_start)         w_state_nxt = S_PREFILL;
  end

  always_ff @(posedge clk_25) begin
    if (!n_rst || frame_start) begin
      r_col       <= '0;
      r_row       <= '0;
      r_rep       <= '0;
      r_line_base <= '0;
    end else if (w_rd) begin
      r_col <= w_last_col ? '0 : r_col + 1'b1;
      if (w_last_col) begin
        r_rep <= w_last_rep ? '0 : r_rep + 1'b1;
        if (w_last_rep) begin
          r_row       <= w_last_row ? '0 : r_row + 1'b1;
          r_line_base <= w_last_row ? '0 : r_line_base + ADDR_W'(H_WORDS);
        end
      end
    end
  end

  always_ff @(posedge clk_25) begin
    if (!n_rst || frame_start) begin
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_inflight <= w_rd;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk_25) begin
    if (w_push) r_fifo[r_wptr] <= mem_rdata;
  end

  always_ff @(posedge clk_25) begin
    if (!n_rst) begin
      r_subpix    <= '0;
      r_underflow <= 1'b0;
      r_pix_hold  <= '0;
    end else begin
      r_pix_hold <= pix_data;
      if (frame_start) begin
        r_subpix    <= '0;
        r_underflow <= 1'b0;
      end else begin
        if (pix_req && !w_empty)
          r_subpix <= (r_subpix == REP_W'(REPS - 1)) ? '0 : r_subpix + 1'b1;
        if (w_uflow) r_underflow <= 1'b1;
      end
    end
  end

  assign underflow = r_underflow;

`ifdef FETCH_STATS_EN
  logic [15:0] r_ucnt;
  always_ff @(posedge clk_25) begin
    if (!n_rst)                      r_ucnt <= '0;
    else if (w_uflow && r_ucnt != '1) r_ucnt <= r_ucnt + 16'd1;
  end
  assign underflow_cnt = r_ucnt;
`else
  assign underflow_cnt = '0;
`endif

endmodule
